// File: rtl/lgca_cell.sv
// Lattice-gas automaton cell: HPP (4-dir) or FHP (6-dir) collision rules with wall
// bounce-back, stochastic FHP pair rotation, direct load and a saturating collision counter.
module lgca_cell #(
    parameter int unsigned N_DIR   = 4,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned RND_EXT = 0,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         step_en,
    input  logic                         load,
    input  logic [N_DIR-1:0]             load_data,
    input  logic                         wall,
    input  logic                         rnd,
    input  logic [N_DIR*N_DIR-1:0]       nbr_in,
    input  logic                         cnt_clr,
    output logic [N_DIR-1:0]             state,
    output logic [$clog2(N_DIR+1)-1:0]   occ,
    output logic [CNT_W-1:0]             coll_cnt
);

    localparam int unsigned HALF  = N_DIR / 2;
    localparam int unsigned OCC_W = $clog2(N_DIR + 1);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

    logic [N_DIR-1:0] r_state;
    logic [15:0]      r_lfsr;
    logic [CNT_W-1:0] r_cnt;

    logic [N_DIR-1:0] w_v;
    logic [N_DIR-1:0] w_refl;
    logic [N_DIR-1:0] w_coll_out;
    logic [N_DIR-1:0] w_next;
    logic             w_coll;
    logic             w_applied;
    logic             w_fb;
    logic             w_unused;

    if ((N_DIR != 4) && (N_DIR != 6)) begin : g_bad_ndir
        $error("lgca_cell: N_DIR must be 4 or 6");
    end

    // A particle moving in direction d arrives from the opposite side's slot d.
    for (genvar d = 0; d < N_DIR; d++) begin : g_dir
        assign w_v[d]    = nbr_in[((d + HALF) % N_DIR) * N_DIR + d];
        assign w_refl[d] = w_v[(d + HALF) % N_DIR];
    end

    if (N_DIR == 4) begin : g_hpp
        assign w_coll     = (w_v == N_DIR'(4'b0101)) || (w_v == N_DIR'(4'b1010));
        assign w_coll_out = ~w_v;
        assign w_unused   = rnd;
    end else begin : g_fhp
        logic w_rnd;
        logic w_pair;
        logic w_tri;
        assign w_rnd  = (RND_EXT != 0) ? rnd : r_lfsr[0];
        assign w_pair = (w_v == N_DIR'(6'b001001)) || (w_v == N_DIR'(6'b010010)) ||
                        (w_v == N_DIR'(6'b100100));
        assign w_tri  = (w_v == N_DIR'(6'b010101)) || (w_v == N_DIR'(6'b101010));
        assign w_coll = w_pair || w_tri;
        // Head-on pairs scatter one way or the other; triples invert.
        assign w_coll_out = w_pair ? (w_rnd ? {w_v[N_DIR-2:0], w_v[N_DIR-1]}
                                            : {w_v[0], w_v[N_DIR-1:1]})
                                   : ~w_v;
        assign w_unused = 1'b0;
    end

    assign w_next    = wall ? w_refl : (w_coll ? w_coll_out : w_v);
    assign w_applied = step_en && !load && !wall && w_coll;
    assign w_fb      = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    // State and LFSR: load beats step; idle cycles hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
            r_lfsr  <= SEED_EFF;
        end else if (load) begin
            r_state <= load_data;
        end else if (step_en) begin
            r_state <= w_next;
            r_lfsr  <= {w_fb, r_lfsr[15:1]};
        end
    end

    // Saturating collision counter with clear priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_applied && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign state    = r_state;
    assign coll_cnt = r_cnt;
    assign occ      = OCC_W'($countones(r_state));

endmodule

// File: tb/tb_lgca_cell.sv
// Scoreboard bench for lgca_cell: three instances (HPP with 2-bit counter, FHP external rnd,
// FHP internal LFSR) driven with directed and random steps against a rule-level model.
module tb_lgca_cell;

    typedef struct packed {
        logic        step;
        logic        load;
        logic        wall;
        logic        clr;
        logic        rnd;
        logic [5:0]  ld;
        logic [35:0] nbr;
    } in_t;

    typedef struct {
        logic [5:0] st;
        logic [7:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    bit   clk_run = 1'b1;
    logic rst_n;
    in_t  din [3];

    logic [3:0] st4;
    logic [2:0] oc4;
    logic [1:0] cnt4;
    logic [5:0] st6e, st6i;
    logic [2:0] oc6e, oc6i;
    logic [7:0] cnt6e, cnt6i;

    logic [5:0]  mstate [3];
    int          mcnt   [3];
    logic [15:0] mlfsr  [3];
    exp_t q0[$], q1[$], q2[$];

    int checks = 0;
    int errors = 0;

    always #5 if (clk_run) clk = ~clk;

    lgca_cell #(.N_DIR(4), .CNT_W(2), .RND_EXT(0)) u4 (
        .clk(clk), .rst_n(rst_n), .step_en(din[0].step), .load(din[0].load),
        .load_data(din[0].ld[3:0]), .wall(din[0].wall), .rnd(din[0].rnd),
        .nbr_in(din[0].nbr[15:0]), .cnt_clr(din[0].clr),
        .state(st4), .occ(oc4), .coll_cnt(cnt4));

    lgca_cell #(.N_DIR(6), .CNT_W(8), .RND_EXT(1)) u6e (
        .clk(clk), .rst_n(rst_n), .step_en(din[1].step), .load(din[1].load),
        .load_data(din[1].ld), .wall(din[1].wall), .rnd(din[1].rnd),
        .nbr_in(din[1].nbr), .cnt_clr(din[1].clr),
        .state(st6e), .occ(oc6e), .coll_cnt(cnt6e));

    lgca_cell #(.N_DIR(6), .CNT_W(8), .RND_EXT(0)) u6i (
        .clk(clk), .rst_n(rst_n), .step_en(din[2].step), .load(din[2].load),
        .load_data(din[2].ld), .wall(din[2].wall), .rnd(din[2].rnd),
        .nbr_in(din[2].nbr), .cnt_clr(din[2].clr),
        .state(st6i), .occ(oc6i), .coll_cnt(cnt6i));

    function automatic int ndir(int k);
        return (k == 0) ? 4 : 6;
    endfunction

    function automatic int cmax(int k);
        return (k == 0) ? 3 : 255;
    endfunction

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endfunction

    // x^16 + x^14 + x^13 + x^11 Fibonacci register, output taken from bit 0
    function automatic logic [15:0] lfsr_next(logic [15:0] l);
        int b;
        b = ((int'(l) >> 0) ^ (int'(l) >> 2) ^ (int'(l) >> 3) ^ (int'(l) >> 5)) & 1;
        return 16'((int'(l) >> 1) | (b << 15));
    endfunction

    // Place v where the cell gathers from; all other neighbour bits are noise.
    function automatic logic [35:0] mk_nbr(int n, logic [5:0] v);
        logic [35:0] x;
        x = 36'({$urandom, $urandom});
        for (int d = 0; d < n; d++) x[((d + n / 2) % n) * n + d] = v[d];
        return x;
    endfunction

    function automatic logic [5:0] pick_v(int n);
        logic [5:0] m;
        m = 6'((1 << n) - 1);
        case ($urandom_range(0, 3))
            1: begin
                if (n == 4) return ($urandom_range(0, 1) != 0) ? 6'h05 : 6'h0A;
                case ($urandom_range(0, 4))
                    0: return 6'h09;
                    1: return 6'h12;
                    2: return 6'h24;
                    3: return 6'h15;
                    default: return 6'h2A;
                endcase
            end
            2: return ($urandom_range(0, 1) != 0) ? m : 6'h00;
            default: return 6'($urandom) & m;
        endcase
    endfunction

    task automatic model_cycle(int k);
        in_t        x;
        int         n;
        logic [5:0] m, v, o;
        bit         coll, r, pair;
        exp_t       e;
        x = din[k];
        n = ndir(k);
        m = 6'((1 << n) - 1);
        v = '0; o = '0; coll = 0; pair = 0;
        for (int d = 0; d < n; d++) v[d] = x.nbr[((d + n / 2) % n) * n + d];
        r = (k == 1) ? x.rnd : mlfsr[k][0];
        if (x.wall) begin
            for (int d = 0; d < n; d++) o[d] = v[(d + n / 2) % n];
        end else begin
            if (n == 6 && $countones(v) == 2)
                for (int d = 0; d < 3; d++) if (v[d] && v[d + 3]) pair = 1;
            if (n == 4 && (v == 6'h05 || v == 6'h0A)) begin
                o = ~v & m; coll = 1;
            end else if (pair) begin
                for (int d = 0; d < n; d++)
                    if (r) o[(d + 1) % n] = v[d];
                    else   o[d] = v[(d + 1) % n];
                coll = 1;
            end else if (n == 6 && (v == 6'h15 || v == 6'h2A)) begin
                o = ~v & m; coll = 1;
            end else begin
                o = v;
            end
        end
        if (x.load) mstate[k] = x.ld & m;
        else if (x.step) begin
            mstate[k] = o;
            mlfsr[k]  = lfsr_next(mlfsr[k]);
        end
        if (x.clr) mcnt[k] = 0;
        else if (!x.load && x.step && coll && mcnt[k] < cmax(k)) mcnt[k]++;
        e.st  = mstate[k];
        e.cnt = 8'(mcnt[k]);
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            din[k].step = 0; din[k].load = 0; din[k].wall = 0; din[k].clr = 0;
            din[k].rnd = 0; din[k].ld = '0; din[k].nbr = mk_nbr(ndir(k), 6'($urandom));
        end
    endtask

    task automatic drv(int k, bit step, bit ld_en, logic [5:0] ld, bit wall, bit clr,
                       bit r, logic [35:0] nbr);
        din[k].step = step; din[k].load = ld_en; din[k].ld = ld; din[k].wall = wall;
        din[k].clr = clr; din[k].rnd = r; din[k].nbr = nbr;
    endtask

    task automatic cycle();
        for (int k = 0; k < 3; k++) model_cycle(k);
        @(posedge clk);
        @(negedge clk);
        idle_all();
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mstate[k] = '0; mcnt[k] = 0; mlfsr[k] = 16'hACE1;
        end
    endtask

    task automatic chk_reset(string tag);
        chk({tag, " u4 state"}, 32'(st4), 0);
        chk({tag, " u4 cnt"}, 32'(cnt4), 0);
        chk({tag, " u4 occ"}, 32'(oc4), 0);
        chk({tag, " u6e state"}, 32'(st6e), 0);
        chk({tag, " u6e cnt"}, 32'(cnt6e), 0);
        chk({tag, " u6i state"}, 32'(st6i), 0);
        chk({tag, " u6i cnt"}, 32'(cnt6i), 0);
        chk({tag, " u6i occ"}, 32'(oc6i), 0);
    endtask

    // Monitor: every cell presents a fresh result one cycle after each issued input set.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("u4 state", 32'(st4), 32'(e.st));
            chk("u4 cnt", 32'(cnt4), 32'(e.cnt));
            chk("u4 occ", 32'(oc4), 32'($countones(e.st)));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("u6e state", 32'(st6e), 32'(e.st));
            chk("u6e cnt", 32'(cnt6e), 32'(e.cnt));
            chk("u6e occ", 32'(oc6e), 32'($countones(e.st)));
        end
        if (q2.size() > 0) begin
            e = q2.pop_front();
            chk("u6i state", 32'(st6i), 32'(e.st));
            chk("u6i cnt", 32'(cnt6i), 32'(e.cnt));
            chk("u6i occ", 32'(oc6i), 32'($countones(e.st)));
        end
    end

    initial begin
        rst_n = 1'b0;
        idle_all();
        model_reset();
        #3;
        chk_reset("por");
        @(negedge clk);
        rst_n = 1'b1;

        // HPP head-on, FHP pair with rnd=1, load beating step
        drv(0, 1, 0, 0, 0, 0, 0, 36'h104);
        drv(1, 1, 0, 0, 0, 0, 1, 36'h000040008);
        drv(2, 1, 1, 6'h3F, 0, 0, 0, mk_nbr(6, 6'h09));
        cycle();
        // HPP wall bounce, FHP pair with rnd=0, first LFSR-driven pair
        drv(0, 1, 0, 0, 1, 0, 0, 36'h100);
        drv(1, 1, 0, 0, 0, 0, 0, 36'h000040008);
        drv(2, 1, 0, 0, 0, 0, 0, mk_nbr(6, 6'h12));
        cycle();
        // no wall pass-through, FHP triple, all-one against a wall
        drv(0, 1, 0, 0, 0, 0, 0, 36'h100);
        drv(1, 1, 0, 0, 0, 0, 0, mk_nbr(6, 6'h15));
        drv(2, 1, 0, 0, 1, 0, 0, mk_nbr(6, 6'h3F));
        cycle();
        // clear wins over a colliding step, then saturation of the 2-bit counter
        drv(0, 1, 0, 0, 0, 1, 0, 36'h104);
        cycle();
        for (int i = 0; i < 5; i++) begin
            drv(0, 1, 0, 0, 0, 0, 0, mk_nbr(4, (i % 2 == 0) ? 6'h05 : 6'h0A));
            cycle();
        end
        drv(0, 1, 0, 0, 0, 1, 0, 36'h104);
        cycle();

        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 3; k++) begin
                din[k].step = ($urandom_range(0, 3) != 0);
                din[k].load = ($urandom_range(0, 9) == 0);
                din[k].wall = ($urandom_range(0, 7) == 0);
                din[k].clr  = ($urandom_range(0, 19) == 0);
                din[k].rnd  = 1'($urandom);
                din[k].ld   = 6'($urandom);
                din[k].nbr  = mk_nbr(ndir(k), pick_v(ndir(k)));
            end
            cycle();
        end

        // make the pre-reset state non-trivial, then reset with the clock stopped
        drv(0, 0, 1, 6'h0F, 0, 0, 0, 36'h0);
        drv(1, 0, 1, 6'h3F, 0, 0, 0, 36'h0);
        drv(2, 1, 0, 0, 0, 0, 0, mk_nbr(6, 6'h2A));
        cycle();
        clk_run = 1'b0;
        #7;
        rst_n = 1'b0;
        #2;
        model_reset();
        chk_reset("async");
        #5;
        rst_n = 1'b1;
        #5;
        clk_run = 1'b1;
        @(negedge clk);
        idle_all();

        // LFSR sequence from the seed, visible through pair rotation direction
        for (int i = 0; i < 40; i++) begin
            drv(2, 1, 0, 0, 0, 0, 0, mk_nbr(6, (i % 3 == 0) ? 6'h09 : ((i % 3 == 1) ? 6'h12 : 6'h24)));
            cycle();
        end

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard drain", 32'(q0.size() + q1.size() + q2.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
